button_debounce: RTL and testbench

- Input-side companion to the LED output path: takes WIDTH raw asynchronous push-button/switch lines, synchronizes and debounces them.
- Produces clean levels, single-cycle rise/fall strobes and per-channel saturating press counters.
- A shared prescaler generates the sampling tick; each channel runs an identical debounce FSM.

---
 rtl/button_debounce_pkg.sv | 20 ++
 rtl/button_debounce_channel.sv | 121 ++++++++++++
 rtl/button_debounce.sv | 64 ++++++
 tb/tb_button_debounce.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer: channel state encoding,
// default parameter values and a counter-width helper.
package button_debounce_pkg;

  typedef enum logic {
    CH_STABLE  = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_e;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_TICK_PERIOD  = 1024;
  localparam int unsigned DEF_STABLE_TICKS = 4;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce channel.
//   CLK, RST : clock, synchronous active-low reset
//   tick     : shared sampling strobe
//   btn      : raw asynchronous input bit
//   clear    : synchronous clear of the press counter
//   level    : debounced level
//   rise     : 1-cycle strobe when level goes 0->1
//   fall     : 1-cycle strobe when level goes 1->0
//   count    : saturating count of rise strobes
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 tick,
  input  logic                 btn,
  input  logic                 clear,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned    SW   = cnt_bits(STABLE_TICKS - 1);
  localparam logic [SW-1:0]  LAST = SW'(STABLE_TICKS - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  ch_state_e            state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 flip;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    flip    = 1'b0;

    if (tick) begin
      case (state_q)
        CH_STABLE: begin
          if (sync2_q != level_q) begin
            if (STABLE_TICKS == 1) begin
              flip = 1'b1;
            end else begin
              cnt_d   = SW'(1);
              state_d = CH_PENDING;
            end
          end
        end
        CH_PENDING: begin
          if (sync2_q == level_q) begin
            cnt_d   = '0;
            state_d = CH_STABLE;
          end else if (cnt_q == LAST) begin
            flip    = 1'b1;
            cnt_d   = '0;
            state_d = CH_STABLE;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      endcase
    end

    if (flip) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
    end

    // Counter follows the registered strobe; clear wins but still
    // absorbs a strobe landing in the same cycle.
    if (clear) begin
      count_d = rise_q ? CNT_WIDTH'(1) : '0;
    end else if (rise_q && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= CH_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign count = count_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer.
//   CLK, RST    : clock, synchronous active-low reset
//   BTN         : raw asynchronous button levels
//   CLEAR       : clears all press counters
//   TICK        : prescaler strobe, high one cycle per TICK_PERIOD
//   LEVEL       : debounced levels
//   RISE, FALL  : 1-cycle edge strobes per channel
//   PRESS_COUNT : channel i in bits [i*CNT_WIDTH +: CNT_WIDTH]
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned TICK_PERIOD  = DEF_TICK_PERIOD,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           BTN,
  input  logic                       CLEAR,
  output logic                       TICK,
  output logic [WIDTH-1:0]           LEVEL,
  output logic [WIDTH-1:0]           RISE,
  output logic [WIDTH-1:0]           FALL,
  output logic [WIDTH*CNT_WIDTH-1:0] PRESS_COUNT
);

  localparam int unsigned   PW         = cnt_bits(TICK_PERIOD - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_PERIOD - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign TICK = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = TICK ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .CLK   (CLK),
      .RST   (RST),
      .tick  (TICK),
      .btn   (BTN[i]),
      .clear (CLEAR),
      .level (LEVEL[i]),
      .rise  (RISE[i]),
      .fall  (FALL[i]),
      .count (PRESS_COUNT[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int unsigned W    = 4;
  localparam int unsigned TP   = 8;
  localparam int unsigned ST   = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = 15;

  logic            CLK;
  logic            RST;
  logic [W-1:0]    BTN;
  logic            CLEAR;
  logic            TICK;
  logic [W-1:0]    LEVEL;
  logic [W-1:0]    RISE;
  logic [W-1:0]    FALL;
  logic [W*CW-1:0] PRESS_COUNT;

  button_debounce #(
    .WIDTH        (W),
    .TICK_PERIOD  (TP),
    .STABLE_TICKS (ST),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BTN         (BTN),
    .CLEAR       (CLEAR),
    .TICK        (TICK),
    .LEVEL       (LEVEL),
    .RISE        (RISE),
    .FALL        (FALL),
    .PRESS_COUNT (PRESS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: sync is BTN two samples back; a channel accepts a new
  // level after ST consecutive tick samples that differ from it.
  int unsigned  cyc;
  logic [W-1:0] bh[$];
  logic [W-1:0] m_level, m_rise, m_fall;
  int unsigned  m_run[W];
  int unsigned  m_cnt[W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W*CW-1:0] exp_counts();
    logic [W*CW-1:0] v;
    v = '0;
    for (int ch = 0; ch < W; ch++) v[ch*CW +: CW] = CW'(m_cnt[ch]);
    return v;
  endfunction

  task automatic step(input logic [W-1:0] b, input logic clr, input logic rst);
    logic [W-1:0] sync;
    logic [W-1:0] dropped;
    logic         tk;
    BTN   = b;
    CLEAR = clr;
    RST   = rst;
    if (!rst) begin
      bh.delete();
      bh.push_back('0);
      bh.push_back('0);
      cyc     = 0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int ch = 0; ch < W; ch++) begin
        m_run[ch] = 0;
        m_cnt[ch] = 0;
      end
    end else begin
      sync = bh[0];
      tk   = (cyc % TP) == TP - 1;
      for (int ch = 0; ch < W; ch++) begin
        if (clr) m_cnt[ch] = m_rise[ch] ? 1 : 0;
        else if (m_rise[ch] && m_cnt[ch] < CMAX) m_cnt[ch]++;
      end
      m_rise = '0;
      m_fall = '0;
      if (tk) begin
        for (int ch = 0; ch < W; ch++) begin
          if (sync[ch] != m_level[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == ST) begin
              m_run[ch]   = 0;
              m_level[ch] = ~m_level[ch];
              if (m_level[ch]) m_rise[ch] = 1'b1;
              else             m_fall[ch] = 1'b1;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
      end
      bh.push_back(b);
      dropped = bh.pop_front();
      cyc++;
    end
    @(posedge CLK);
    #1;
    chk("tick",        32'(TICK),        32'((cyc % TP) == TP - 1));
    chk("level",       32'(LEVEL),       32'(m_level));
    chk("rise",        32'(RISE),        32'(m_rise));
    chk("fall",        32'(FALL),        32'(m_fall));
    chk("press_count", 32'(PRESS_COUNT), 32'(exp_counts()));
    chk("rise_and_fall_exclusive", 32'(RISE & FALL), 32'd0);
  endtask

  task automatic align_after_tick();
    for (int k = 0; k < TP && (cyc % TP) != 0; k++) step('0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0]    btn;
    logic            clr;
    int unsigned     ncyc;
    logic [W-1:0]    exp_level;
    logic [W*CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned  n;
    int unsigned  strobes;
    logic [W-1:0] rb;
    logic         rc;

    vecs[0] = '{btn: 4'b0000, clr: 1'b0, ncyc: 16, exp_level: 4'b0000, exp_cnt: 16'h0000};
    vecs[1] = '{btn: 4'b0001, clr: 1'b0, ncyc: 40, exp_level: 4'b0001, exp_cnt: 16'h0001};
    vecs[2] = '{btn: 4'b0000, clr: 1'b0, ncyc: 40, exp_level: 4'b0000, exp_cnt: 16'h0001};
    vecs[3] = '{btn: 4'b1011, clr: 1'b0, ncyc: 40, exp_level: 4'b1011, exp_cnt: 16'h1012};
    vecs[4] = '{btn: 4'b0000, clr: 1'b0, ncyc: 40, exp_level: 4'b0000, exp_cnt: 16'h1012};
    vecs[5] = '{btn: 4'b0000, clr: 1'b1, ncyc: 1,  exp_level: 4'b0000, exp_cnt: 16'h0000};
    vecs[6] = '{btn: 4'b0100, clr: 1'b0, ncyc: 40, exp_level: 4'b0100, exp_cnt: 16'h0100};
    vecs[7] = '{btn: 4'b0000, clr: 1'b0, ncyc: 40, exp_level: 4'b0000, exp_cnt: 16'h0100};

    BTN = '0; CLEAR = 1'b0; RST = 1'b0;
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("reset_outputs", 32'({TICK, LEVEL, RISE, FALL, PRESS_COUNT}), 32'd0);

    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < int'(vecs[v].ncyc); c++) step(vecs[v].btn, vecs[v].clr, 1'b1);
      chk($sformatf("vec%0d_level", v), 32'(LEVEL), 32'(vecs[v].exp_level));
      chk($sformatf("vec%0d_count", v), 32'(PRESS_COUNT), 32'(vecs[v].exp_cnt));
    end

    // Bounce: high for two ticks only, then a short pulse between ticks.
    align_after_tick();
    strobes = 0;
    for (int c = 0; c < 14; c++) begin
      step(4'b0010, 1'b0, 1'b1);
      strobes += RISE[1] + FALL[1];
    end
    for (int c = 0; c < 30; c++) begin
      step(4'b0000, 1'b0, 1'b1);
      strobes += RISE[1] + FALL[1];
    end
    align_after_tick();
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b0, 1'b1);
      strobes += RISE[1] + FALL[1];
    end
    for (int c = 0; c < 30; c++) begin
      step(4'b0000, 1'b0, 1'b1);
      strobes += RISE[1] + FALL[1];
    end
    chk("bounce_strobes", strobes, 32'd0);
    chk("bounce_level", 32'(LEVEL), 32'd0);
    chk("bounce_count", 32'(PRESS_COUNT), 32'h0100);

    // Saturation: 17 presses on channel 2 from a cleared counter.
    step('0, 1'b1, 1'b1);
    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < 40; c++) step(4'b0100, 1'b0, 1'b1);
      for (int c = 0; c < 40; c++) step(4'b0000, 1'b0, 1'b1);
    end
    chk("saturate_count", 32'(PRESS_COUNT), 32'h0F00);

    // Clear in the same cycle RISE[3] is visible.
    n = 0;
    while (!m_rise[3] && n < 60) begin
      step(4'b1000, 1'b0, 1'b1);
      n++;
    end
    chk("clear_rise_seen", 32'(RISE[3]), 32'd1);
    step(4'b1000, 1'b1, 1'b1);
    chk("clear_with_rise", 32'(PRESS_COUNT), 32'h1000);
    for (int c = 0; c < 40; c++) step(4'b0000, 1'b0, 1'b1);

    // Reset mid-debounce with the button still held.
    align_after_tick();
    n = 0;
    while (m_run[0] != 2 && n < 60) begin
      step(4'b0001, 1'b0, 1'b1);
      n++;
    end
    step(4'b0001, 1'b0, 1'b0);
    chk("midreset_outputs", 32'({TICK, LEVEL, RISE, FALL, PRESS_COUNT}), 32'd0);
    n = 0;
    while (LEVEL[0] !== 1'b1 && n < 60) begin
      step(4'b0001, 1'b0, 1'b1);
      n++;
    end
    chk("held_latency", n, 32'(ST * TP));
    chk("held_rise", 32'(RISE), 32'b0001);
    step(4'b0001, 1'b0, 1'b1);
    chk("held_count", 32'(PRESS_COUNT), 32'h0001);

    // Random bouncing with occasional clears.
    rb = 4'b0001;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(11) == 0) rb[b] = ~rb[b];
      rc = ($urandom_range(49) == 0);
      step(rb, rc, 1'b1);
    end
    for (int c = 0; c < 40; c++) step('0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
